// File: rtl/vga_pkg.sv
// Shared constants, stage-1 record and width helpers for the VGA tile display.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic [11:0] DEF_BG_COLOR     = 12'h000;
    localparam logic [11:0] DEF_WALL_COLOR   = 12'hFF0;
    localparam logic [11:0] DEF_PLAYER_COLOR = 12'hFFF;

    localparam int unsigned DEF_TILE     = 20;
    localparam int unsigned DEF_MAP_COLS = 32;
    localparam int unsigned DEF_MAP_ROWS = 24;

    localparam int unsigned POS_W = 8;

    // Per-pixel attributes carried from the tile lookup to the output registers.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic player;
        logic wall;
    } vga_s1_t;

    function automatic int unsigned vga_width(input int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

    function automatic int unsigned vga_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, h/v scan counters, raw sync/active windows and frame-wrap pulse.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = vga_width(H_TOTAL),
    localparam int unsigned VW      = vga_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          o_pix_en,
    output logic [HW-1:0] o_h_count,
    output logic [VW-1:0] o_v_count,
    output logic          o_line_end,
    output logic          o_frame_wrap,
    output logic          o_h_sync_win,
    output logic          o_v_sync_win,
    output logic          o_active
);

    localparam int unsigned DW = vga_width(CLK_DIV);

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_pix_en;
    logic          w_h_last;
    logic          w_v_last;

    assign w_pix_en = (r_div == DW'(CLK_DIV - 1));
    assign w_h_last = (r_h == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_en) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Compare in 32 bits so an upper bound equal to the total cannot alias to zero.
    assign o_h_sync_win = (32'(r_h) >= H_ACTIVE + H_FP) && (32'(r_h) < H_ACTIVE + H_FP + H_SYNC);
    assign o_v_sync_win = (32'(r_v) >= V_ACTIVE + V_FP) && (32'(r_v) < V_ACTIVE + V_FP + V_SYNC);
    assign o_active     = (32'(r_h) < H_ACTIVE) && (32'(r_v) < V_ACTIVE);

    assign o_pix_en     = w_pix_en;
    assign o_h_count    = r_h;
    assign o_v_count    = r_v;
    assign o_line_end   = w_pix_en & w_h_last;
    assign o_frame_wrap = w_pix_en & w_h_last & w_v_last;

endmodule

// File: rtl/vga_tile_display.sv
// VGA scan-out of a ROM tile map with a one-tile player overlay latched once per frame.
module vga_tile_display
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_FP         = DEF_H_FP,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BP         = DEF_H_BP,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_FP         = DEF_V_FP,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BP         = DEF_V_BP,
    parameter logic        SYNC_POL     = 1'b0,
    parameter int unsigned TILE         = DEF_TILE,
    parameter int unsigned MAP_COLS     = DEF_MAP_COLS,
    parameter int unsigned MAP_ROWS     = DEF_MAP_ROWS,
    parameter logic [11:0] BG_COLOR     = DEF_BG_COLOR,
    parameter logic [11:0] WALL_COLOR   = DEF_WALL_COLOR,
    parameter logic [11:0] PLAYER_COLOR = DEF_PLAYER_COLOR,
    localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW          = vga_width(H_TOTAL),
    localparam int unsigned VW          = vga_width(V_TOTAL),
    localparam int unsigned AW          = vga_width(MAP_ROWS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [POS_W-1:0]    player_x,
    input  logic [POS_W-1:0]    player_y,
    output logic [AW-1:0]       map_addr,
    input  logic [MAP_COLS-1:0] map_row,
    output logic                hsync,
    output logic                vsync,
    output logic [11:0]         rgb,
    output logic                de,
    output logic                frame_start,
    output logic [HW-1:0]       h_count,
    output logic [VW-1:0]       v_count
);

    // Tile counters keep running through blanking, so size them for the full totals.
    localparam int unsigned TXW = vga_width(TILE);
    localparam int unsigned CW  = vga_max(POS_W, vga_width(H_TOTAL / TILE + 1));
    localparam int unsigned RW  = vga_max(POS_W, vga_width(V_TOTAL / TILE + 1));

    logic          w_pix_en;
    logic          w_line_end;
    logic          w_frame_wrap;
    logic          w_h_sync_win;
    logic          w_v_sync_win;
    logic          w_active;
    logic [HW-1:0] w_h_count;
    logic [VW-1:0] w_v_count;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk          (clk),
        .reset_n      (reset_n),
        .o_pix_en     (w_pix_en),
        .o_h_count    (w_h_count),
        .o_v_count    (w_v_count),
        .o_line_end   (w_line_end),
        .o_frame_wrap (w_frame_wrap),
        .o_h_sync_win (w_h_sync_win),
        .o_v_sync_win (w_v_sync_win),
        .o_active     (w_active)
    );

    logic [TXW-1:0]   r_tile_x;
    logic [TXW-1:0]   r_tile_y;
    logic [CW-1:0]    r_tile_col;
    logic [RW-1:0]    r_tile_row;
    logic [POS_W-1:0] r_px;
    logic [POS_W-1:0] r_py;

    // Stage 0: tile position tracks the counters by increment and wrap only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tile_x   <= '0;
            r_tile_col <= '0;
            r_tile_y   <= '0;
            r_tile_row <= '0;
        end else if (w_pix_en) begin
            if (w_line_end) begin
                r_tile_x   <= '0;
                r_tile_col <= '0;
                if (w_frame_wrap) begin
                    r_tile_y   <= '0;
                    r_tile_row <= '0;
                end else if (r_tile_y == TXW'(TILE - 1)) begin
                    r_tile_y   <= '0;
                    r_tile_row <= r_tile_row + 1'b1;
                end else begin
                    r_tile_y <= r_tile_y + 1'b1;
                end
            end else if (r_tile_x == TXW'(TILE - 1)) begin
                r_tile_x   <= '0;
                r_tile_col <= r_tile_col + 1'b1;
            end else begin
                r_tile_x <= r_tile_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_px <= '0;
            r_py <= '0;
        end else if (w_frame_wrap) begin
            r_px <= player_x;
            r_py <= player_y;
        end
    end

    logic w_col_in;
    logic w_row_in;
    logic w_map_bit;
    logic w_player_on_map;

    assign w_col_in  = (32'(r_tile_col) < MAP_COLS);
    assign w_row_in  = (32'(r_tile_row) < MAP_ROWS);
    assign map_addr  = w_row_in ? AW'(r_tile_row) : '0;
    assign w_map_bit = |(map_row & (MAP_COLS'(1) << r_tile_col));

    assign w_player_on_map = (32'(r_px) < MAP_COLS) && (32'(r_py) < MAP_ROWS);

    vga_s1_t w_s1_next;
    vga_s1_t r_s1;

    // Stage 1: map_row has settled for the current tile_row by the next pix_en.
    always_comb begin
        w_s1_next        = '0;
        w_s1_next.active = w_active;
        w_s1_next.hsync  = w_h_sync_win;
        w_s1_next.vsync  = w_v_sync_win;
        w_s1_next.wall   = w_col_in & w_row_in & w_map_bit;
        w_s1_next.player = w_player_on_map && (r_tile_col == CW'(r_px))
                           && (r_tile_row == RW'(r_py));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
        end else if (w_pix_en) begin
            r_s1 <= w_s1_next;
        end
    end

    logic [11:0] w_rgb_next;

    always_comb begin
        w_rgb_next = 12'h000;
        if (r_s1.active) begin
            if (r_s1.player) begin
                w_rgb_next = PLAYER_COLOR;
            end else if (r_s1.wall) begin
                w_rgb_next = WALL_COLOR;
            end else begin
                w_rgb_next = BG_COLOR;
            end
        end
    end

    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [11:0] r_rgb;

    // Stage 2: all pin-facing outputs leave from flops, aligned two pixels behind stage 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_de    <= 1'b0;
            r_rgb   <= 12'h000;
        end else if (w_pix_en) begin
            r_hsync <= r_s1.hsync ? SYNC_POL : ~SYNC_POL;
            r_vsync <= r_s1.vsync ? SYNC_POL : ~SYNC_POL;
            r_de    <= r_s1.active;
            r_rgb   <= w_rgb_next;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign rgb         = r_rgb;
    assign frame_start = w_frame_wrap;
    assign h_count     = w_h_count;
    assign v_count     = w_v_count;

endmodule

// File: tb/tb_vga_tile_display.sv
// Directed bench for vga_tile_display on a small 32x20 mode with 4-pixel tiles.
module tb_vga_tile_display;

    localparam int unsigned CLK_DIV   = 3;
    localparam int unsigned H_TOTAL   = 32;
    localparam int unsigned V_TOTAL   = 20;
    localparam int unsigned FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam int          WAIT_MAX  = 4000;

    logic        clk;
    logic        reset_n;
    logic [7:0]  player_x;
    logic [7:0]  player_y;
    logic [1:0]  map_addr;
    logic [3:0]  map_row;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        de;
    logic        frame_start;
    logic [4:0]  h_count;
    logic [4:0]  v_count;

    logic [3:0]  rom [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fs_count = 0;
    int fs_last  = 0;
    int fs_prev  = 0;
    int n_de, n_hs, n_vs, n_fs;

    vga_tile_display #(
        .CLK_DIV      (CLK_DIV),
        .H_ACTIVE     (24),
        .H_FP         (2),
        .H_SYNC       (3),
        .H_BP         (3),
        .V_ACTIVE     (16),
        .V_FP         (1),
        .V_SYNC       (2),
        .V_BP         (1),
        .SYNC_POL     (1'b0),
        .TILE         (4),
        .MAP_COLS     (4),
        .MAP_ROWS     (3),
        .BG_COLOR     (12'h000),
        .WALL_COLOR   (12'hFF0),
        .PLAYER_COLOR (12'hFFF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .player_x    (player_x),
        .player_y    (player_y),
        .map_addr    (map_addr),
        .map_row     (map_row),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .de          (de),
        .frame_start (frame_start),
        .h_count     (h_count),
        .v_count     (v_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data one clk after the address.
    always @(posedge clk) map_row <= rom[map_addr];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (frame_start === 1'b1) begin
            fs_count <= fs_count + 1;
            fs_last  <= cyc;
            fs_prev  <= fs_last;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leave the current position if it already matches, then stop at the next (h,v).
    task automatic wait_hv(input int h, input int v);
        int n;
        n = 0;
        while (int'(h_count) == h && int'(v_count) == v && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        while (!(int'(h_count) == h && int'(v_count) == v) && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) check_eq("wait_hv", {h_count, v_count}, {5'(h), 5'(v)});
    endtask

    // Outputs at counter (h,v) describe the pixel two positions earlier.
    task automatic px(input string tag, input int h, input int v,
                      input logic [11:0] exp_rgb, input logic exp_de);
        wait_hv(h, v);
        check_eq(tag, rgb, exp_rgb);
        check_eq(tag, de, exp_de);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rgb", rgb, 12'h000);
        check_eq("rst_de", de, 1'b0);
        check_eq("rst_hsync", hsync, 1'b1);
        check_eq("rst_vsync", vsync, 1'b1);
        check_eq("rst_map_addr", map_addr, 2'd0);
        check_eq("rst_frame_start", frame_start, 1'b0);
        check_eq("rst_h_count", h_count, 5'd0);
        check_eq("rst_v_count", v_count, 5'd0);
    endtask

    task automatic release_and_check();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (CLK_DIV - 1) @(posedge clk);
        #1 check_eq("h_before_first_pix", h_count, 5'd0);
        @(posedge clk);
        #1 check_eq("h_after_clk_div", h_count, 5'd1);
    endtask

    initial begin
        reset_n  = 1'b0;
        player_x = 8'd1;
        player_y = 8'd2;
        rom[0]   = 4'b0001;
        rom[1]   = 4'b0100;
        rom[2]   = 4'b1010;
        repeat (4) @(negedge clk);
        check_reset_outputs();
        release_and_check();

        // Frame 0 uses the reset-latched position (0,0).
        px("f0_player_at_origin", 2, 0, 12'hFFF, 1'b1);
        check_eq("no_fs_after_reset", fs_count, 0);

        // Frame 1: player (1,2) latched at the first wrap.
        px("f1_wall_0_0", 2, 0, 12'hFF0, 1'b1);
        check_eq("fs_first_wrap", fs_count, 1);
        px("f1_bg_4_0", 6, 0, 12'h000, 1'b1);
        player_x = 8'd5;
        player_y = 8'd2;
        px("f1_last_active", 25, 0, 12'h000, 1'b1);
        px("f1_front_porch", 27, 0, 12'h000, 1'b0);
        check_eq("hsync_before_win", hsync, 1'b1);
        wait_hv(28, 0);
        check_eq("hsync_win_start", hsync, 1'b0);
        wait_hv(30, 0);
        check_eq("hsync_win_end", hsync, 1'b0);
        wait_hv(31, 0);
        check_eq("hsync_after_win", hsync, 1'b1);
        px("f1_above_wall", 10, 3, 12'h000, 1'b1);
        px("f1_left_of_wall", 9, 4, 12'h000, 1'b1);
        check_eq("map_addr_row1", map_addr, 2'd1);
        px("f1_wall_tl", 10, 4, 12'hFF0, 1'b1);
        px("f1_right_of_wall", 14, 4, 12'h000, 1'b1);
        px("f1_wall_br", 13, 7, 12'hFF0, 1'b1);
        px("f1_left_of_player", 5, 8, 12'h000, 1'b1);
        px("f1_player_over_wall", 6, 8, 12'hFFF, 1'b1);
        check_eq("map_addr_row2", map_addr, 2'd2);
        px("f1_right_of_player", 10, 8, 12'h000, 1'b1);
        px("f1_wall_3_2", 14, 9, 12'hFF0, 1'b1);
        px("f1_player_br", 9, 11, 12'hFFF, 1'b1);
        px("f1_row_off_map", 2, 12, 12'h000, 1'b1);
        check_eq("map_addr_off_map", map_addr, 2'd0);
        px("f1_v_blank", 2, 16, 12'h000, 1'b0);
        wait_hv(1, 17);
        check_eq("vsync_before_win", vsync, 1'b1);
        wait_hv(2, 17);
        check_eq("vsync_win_start", vsync, 1'b0);
        wait_hv(1, 19);
        check_eq("vsync_win_end", vsync, 1'b0);
        wait_hv(2, 19);
        check_eq("vsync_after_win", vsync, 1'b1);

        // Frame 2: off-map column latched, so the old player tile shows the wall again.
        px("f2_old_player_tile", 6, 8, 12'hFF0, 1'b1);
        check_eq("fs_second_wrap", fs_count, 2);
        check_eq("fs_period_clk", fs_last - fs_prev, FRAME_CLK);
        px("f2_player_off_map_col", 22, 8, 12'h000, 1'b1);
        player_x = 8'd3;
        player_y = 8'd3;

        // Frame 3: off-map row latched.
        px("f3_wall_0_0", 2, 0, 12'hFF0, 1'b1);
        px("f3_player_off_map_row", 14, 12, 12'h000, 1'b1);

        n_de = 0;
        n_hs = 0;
        n_vs = 0;
        n_fs = 0;
        for (int i = 0; i < int'(FRAME_CLK); i++) begin
            @(negedge clk);
            if (de) n_de++;
            if (!hsync) n_hs++;
            if (!vsync) n_vs++;
            if (frame_start) n_fs++;
        end
        check_eq("de_clk_per_frame", n_de, 1152);
        check_eq("hsync_low_clk_per_frame", n_hs, 180);
        check_eq("vsync_low_clk_per_frame", n_vs, 192);
        check_eq("fs_per_frame", n_fs, 1);

        // Reset mid-line inside a wall tile.
        px("pre_reset_wall", 10, 5, 12'hFF0, 1'b1);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs();
        release_and_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
